gf2m_digit_serial_mul: RTL and testbench

//  Digit-serial GF(2^m) multiplier with built-in modular reduction. Successor to the

---
 rtl/gf2m_digit_serial_mul.sv | 125 ++++++++++++
 tb/tb_gf2m_digit_serial_mul.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gf2m_digit_serial_mul.sv
// gf2m_digit_serial_mul: digit-serial GF(2^M) multiplier, one B-digit per clock MSD first, start/done handshake.
// Define GF2M_MUL_SQR_EN to add the sqr port for a single-pass squaring mode.
module gf2m_digit_serial_mul #(
    parameter int M = 163,
    parameter int D = 8,
    parameter logic [M-1:0] POLY = 163'hC9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef GF2M_MUL_SQR_EN
    input  logic         sqr,
`endif
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [M-1:0] result
);
    localparam int N  = (M + D - 1) / D;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    function automatic int poly_deg(input logic [M-1:0] p);
        poly_deg = 0;
        for (int i = 0; i < M; i++) if (p[i]) poly_deg = i;
    endfunction

    localparam int PDEG = poly_deg(POLY);

    // a single fold must bring every overflow bit below x^M
    generate
        if (D < 1 || D > M - PDEG) begin : g_bad_d
            $error("gf2m_digit_serial_mul: D must satisfy 1 <= D <= M - deg(POLY)");
        end
    endgenerate

    function automatic logic [M-1:0] fold(input logic [M+D-1:0] v);
        fold = v[M-1:0];
        for (int i = 0; i < D; i++) if (v[M+i]) fold ^= POLY << i;
    endfunction

    function automatic logic [M+D-1:0] clmul(input logic [M-1:0] x, input logic [D-1:0] y);
        clmul = '0;
        for (int j = 0; j < D; j++) if (y[j]) clmul ^= {{D{1'b0}}, x} << j;
    endfunction

`ifdef GF2M_MUL_SQR_EN
    // squaring interleaves zeros, then reduces from the top bit down
    function automatic logic [M-1:0] square(input logic [M-1:0] x);
        logic [2*M-1:0] v;
        v = '0;
        for (int i = 0; i < M; i++) v[2*i] = x[i];
        for (int i = 2*M-2; i >= M; i--) begin
            if (v[i]) begin
                v[i-M +: M] ^= POLY;
                v[i] = 1'b0;
            end
        end
        square = v[M-1:0];
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [M-1:0]     a_q, a_d, acc_q, acc_d, result_q, result_d, acc_nx, sq_res;
    logic [N*D-1:0]   b_q, b_d, b_pad;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [D-1:0]     digit;
    logic             accept, busy, last, use_sqr;

`ifdef GF2M_MUL_SQR_EN
    assign use_sqr = sqr;
    assign sq_res  = square(a);
`else
    assign use_sqr = 1'b0;
    assign sq_res  = '0;
`endif

    assign accept = state_q == IDLE && start;
    assign busy   = state_q == BUSY;
    assign last   = cnt_q == '0;
    assign digit  = b_q[int'(cnt_q)*D +: D];
    assign acc_nx = fold({acc_q, {D{1'b0}}} ^ clmul(a_q, digit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = accept ? (use_sqr ? DONE : BUSY) :
                  (busy && last) ? DONE :
                  state_q == DONE ? IDLE : state_q;
    end

    always_comb begin
        b_pad          = '0;
        b_pad[M-1:0]   = b;
        a_d            = accept ? a : a_q;
        b_d            = accept ? b_pad : b_q;
        acc_d          = accept ? '0 : busy ? acc_nx : acc_q;
        cnt_d          = accept ? CW'(N - 1) : busy ? cnt_q - CW'(1) : cnt_q;
        result_d       = (busy && last) ? acc_nx : (accept && use_sqr) ? sq_res : result_q;
    end

    always_comb begin
        ready  = state_q == IDLE;
        done   = state_q == DONE;
        result = result_q;
    end
endmodule

// File: tb/tb_gf2m_digit_serial_mul.sv
// tb_gf2m_digit_serial_mul: directed checks of latency, handshake, reset abort and known field products.
// Four instances cover M=163/D=8, M=8/D=3, M=8/D=4 and the D=M case M=4/D=4 with f=x^4+1.
module tb_gf2m_digit_serial_mul;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   st = '0;
    logic         sqr = 1'b0;
    logic [162:0] a163 = '0, b163 = '0;
    logic [7:0]   a8 = '0, b8 = '0;
    logic [3:0]   a4 = '0, b4 = '0;
    logic [3:0]   rdy, dn;
    logic [162:0] r163;
    logic [7:0]   r8a, r8b;
    logic [3:0]   r4;
    logic [1:0]   cur = '0;
    logic         dm, rdy_m;
    logic [162:0] rm;
    int           pass = 0, total = 0;

    always #5 clk = ~clk;

    gf2m_digit_serial_mul #(.M(163), .D(8), .POLY(163'hC9)) u0 (
        .clk(clk), .rst(rst), .start(st[0]),
`ifdef GF2M_MUL_SQR_EN
        .sqr(sqr),
`endif
        .a(a163), .b(b163), .ready(rdy[0]), .done(dn[0]), .result(r163));

    gf2m_digit_serial_mul #(.M(8), .D(3), .POLY(8'h1B)) u1 (
        .clk(clk), .rst(rst), .start(st[1]),
`ifdef GF2M_MUL_SQR_EN
        .sqr(sqr),
`endif
        .a(a8), .b(b8), .ready(rdy[1]), .done(dn[1]), .result(r8a));

    gf2m_digit_serial_mul #(.M(8), .D(4), .POLY(8'h1B)) u2 (
        .clk(clk), .rst(rst), .start(st[2]),
`ifdef GF2M_MUL_SQR_EN
        .sqr(sqr),
`endif
        .a(a8), .b(b8), .ready(rdy[2]), .done(dn[2]), .result(r8b));

    gf2m_digit_serial_mul #(.M(4), .D(4), .POLY(4'h1)) u3 (
        .clk(clk), .rst(rst), .start(st[3]),
`ifdef GF2M_MUL_SQR_EN
        .sqr(sqr),
`endif
        .a(a4), .b(b4), .ready(rdy[3]), .done(dn[3]), .result(r4));

    always_comb begin
        dm    = dn[cur];
        rdy_m = rdy[cur];
        rm    = cur == 2'd0 ? r163 : cur == 2'd1 ? 163'(r8a) : cur == 2'd2 ? 163'(r8b) : 163'(r4);
    end

    task automatic chk(input logic [162:0] obs, input logic [162:0] exp, input string tag);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run(input logic [1:0] s, input logic [162:0] av, input logic [162:0] bv,
                       input logic [162:0] ex, input int lat, input string tag);
        int cyc, nlow;
        cur = s;
        a163 = av; b163 = bv; a8 = av[7:0]; b8 = bv[7:0]; a4 = av[3:0]; b4 = bv[3:0];
        st[s] = 1'b1;
        @(posedge clk); #1;
        st[s] = 1'b0;
        a163 = ~av; b163 = ~bv; a8 = ~av[7:0]; b8 = ~bv[7:0]; a4 = ~av[3:0]; b4 = ~bv[3:0];
        cyc = 1;
        nlow = 0;
        while (!dm && cyc < 200) begin
            nlow += int'(!rdy_m);
            @(posedge clk); #1;
            cyc++;
        end
        nlow += int'(!rdy_m);
        chk(163'(cyc), 163'(lat), {tag, " done cycle"});
        chk(163'(nlow), 163'(lat), {tag, " ready-low cycles"});
        chk(rm, ex, {tag, " result"});
        @(posedge clk); #1;
        chk(163'(dm), 163'd0, {tag, " done single pulse"});
        chk(163'(rdy_m), 163'd1, {tag, " ready back"});
    endtask

    localparam logic [162:0] X162 = 163'd1 << 162;
    localparam logic [162:0] X200 = (163'd1 << 44) | (163'd1 << 43) | (163'd1 << 40) | (163'd1 << 37);

    initial begin
        #1;
        chk(163'(rdy), 163'hF, "reset ready");
        chk(163'(dn), 163'h0, "reset done");
        chk(r163, 163'h0, "reset result");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run(0, 163'd1, 163'd1, 163'd1, 22, "one_times_one");
        run(0, X162, 163'd2, 163'hC9, 22, "x162_times_x");
        run(0, 163'd0, 163'd0, 163'd0, 22, "zero_times_zero");
        run(0, X162, 163'd4, 163'h192, 22, "x162_times_x2");
        run(0, 163'd3, X162, X162 | 163'hC9, 22, "xp1_times_x162");
        run(0, 163'd1 << 5, (163'd1 << 160) | 163'd8, 163'h224, 22, "x5_times_x160x3");
        run(0, 163'd1 << 100, 163'd1 << 100, X200, 22, "x100_squared_mul");
        run(1, 163'h57, 163'h83, 163'hC1, 4, "aes_d3");
        run(1, 163'h02, 163'h80, 163'h1B, 4, "x_times_x7_d3");
        run(2, 163'h57, 163'h83, 163'hC1, 3, "aes_d4");
        run(3, 163'h6, 163'h6, 163'h5, 2, "d_eq_m");
        // start pulses while busy must be ignored; then start held across done
        cur = 2'd0;
        a163 = X162; b163 = 163'd2; st[0] = 1'b1;
        @(posedge clk); #1;
        a163 = 163'h5; b163 = 163'h7;
        for (int c = 1; c <= 21; c++) begin
            st[0] = (c == 5 || c == 12);
            @(posedge clk); #1;
        end
        chk(163'(dm), 163'd1, "ignored_start done cycle22");
        chk(rm, 163'hC9, "ignored_start result");
        a163 = X162; b163 = 163'd4; st[0] = 1'b1;
        @(posedge clk); #1;
        chk(163'(rdy_m), 163'd1, "held_start idle");
        chk(rm, 163'hC9, "held_start result held");
        @(posedge clk); #1;
        st[0] = 1'b0;
        a163 = '0; b163 = '0;
        chk(163'(rdy_m), 163'd0, "held_start accepted");
        repeat (10) begin @(posedge clk); #1; end
        chk(rm, 163'hC9, "b2b result held mid-op");
        repeat (11) begin @(posedge clk); #1; end
        chk(163'(dm), 163'd1, "b2b done");
        chk(rm, 163'h192, "b2b result");
        @(posedge clk); #1;
        // asynchronous reset mid-operation
        a163 = 163'd1 << 5; b163 = (163'd1 << 160) | 163'd8; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk(163'(rdy_m), 163'd1, "abort ready");
        chk(163'(dm), 163'd0, "abort done");
        chk(rm, 163'd0, "abort result");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk(163'(rdy_m), 163'd1, "abort stays idle");
        run(0, 163'd1 << 5, (163'd1 << 160) | 163'd8, 163'h224, 22, "after_abort");
`ifdef GF2M_MUL_SQR_EN
        sqr = 1'b1;
        run(0, 163'd1 << 100, 163'h1234, X200, 1, "sqr_x100");
        sqr = 1'b0;
        run(1, 163'h57, 163'h83, 163'hC1, 4, "sqr_off_aes");
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
